// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: two-requester round-robin frame scheduler that hands
// one frame at a time to a serial transmitter and reports completion.
// Optional feature macro: TX_SCHED_CRC_EN adds a CRC-8 pass (poly 0x07,
// init 0x00, MSB first) over the frame bytes before launch; without it the
// crc output is tied to 8'h00 and launch follows the grant directly.
module tx_frame_scheduler (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [1:0]   req_valid,
    input  logic [3:0]   req_size0,
    input  logic [3:0]   req_size1,
    input  logic [127:0] req_bits0,
    input  logic [127:0] req_bits1,
    output logic [1:0]   req_ack,
    input  logic [7:0]   cfg_baud,
    input  logic         cfg_baud_we,
    input  logic         txi,
    output logic         tf,
    output logic [3:0]   framesize,
    output logic [127:0] framebits,
    output logic [7:0]   crc,
    output logic [7:0]   baudrate,
    output logic         busy,
    output logic         done,
    output logic         done_id,
    output logic         err
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CRC        = 3'd1,
        ST_LAUNCH     = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_WAIT_END   = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic           last_q, last_d;
    logic           gnt_id_q, gnt_id_d;
    logic [3:0]     size_q, size_d;
    logic [127:0]   bits_q, bits_d;
    logic [7:0]     baud_out_q, baud_out_d;
    logic [7:0]     baud_reg_q, baud_reg_d;
    logic [3:0]     wait_cnt_q, wait_cnt_d;
    logic           done_q, done_d;
    logic           done_id_q, done_id_d;
    logic           err_q, err_d;

    logic           gnt_any_s;
    logic           gnt_sel_s;
    logic [3:0]     sel_size_s;
    logic [127:0]   sel_bits_s;

`ifdef TX_SCHED_CRC_EN
    logic [7:0]     crc_q, crc_d;
    logic [3:0]     byte_idx_q, byte_idx_d;

    // One byte of CRC-8 (poly 0x07), MSB first.
    function automatic logic [7:0] crc8_byte(input logic [7:0] c_in, input logic [7:0] data);
        logic [7:0] c;
        c = c_in ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ 8'h07;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction
`endif

    // Round-robin arbitration: on a tie the requester not granted last wins.
    always_comb begin
        gnt_any_s = (state_q == ST_IDLE) && (req_valid != 2'b00) && txi;
        if (req_valid == 2'b11) begin
            gnt_sel_s = ~last_q;
        end else begin
            gnt_sel_s = req_valid[1];
        end
        if (gnt_sel_s) begin
            sel_size_s = req_size1;
            sel_bits_s = req_bits1;
        end else begin
            sel_size_s = req_size0;
            sel_bits_s = req_bits0;
        end
    end

    // Ack is combinational so it lands in the grant cycle; masked during reset.
    always_comb begin
        if (gnt_any_s && reset_n) begin
            req_ack = gnt_sel_s ? 2'b10 : 2'b01;
        end else begin
            req_ack = 2'b00;
        end
    end

    // Next-state and datapath update for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_id_d   = gnt_id_q;
        size_d     = size_q;
        bits_d     = bits_q;
        baud_out_d = baud_out_q;
        wait_cnt_d = wait_cnt_q;
        done_d     = 1'b0;
        done_id_d  = done_id_q;
        err_d      = 1'b0;
`ifdef TX_SCHED_CRC_EN
        crc_d      = crc_q;
        byte_idx_d = byte_idx_q;
`endif
        // A zero divisor is never stored.
        if (cfg_baud_we && (cfg_baud != 8'h00)) begin
            baud_reg_d = cfg_baud;
        end else begin
            baud_reg_d = baud_reg_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (gnt_any_s) begin
                    last_d     = gnt_sel_s;
                    gnt_id_d   = gnt_sel_s;
                    size_d     = sel_size_s;
                    bits_d     = sel_bits_s;
                    // A same-cycle baud write applies to this grant.
                    baud_out_d = baud_reg_d;
`ifdef TX_SCHED_CRC_EN
                    crc_d      = 8'h00;
                    byte_idx_d = 4'd0;
`endif
                    if (sel_size_s == 4'd0) begin
                        done_d    = 1'b1;
                        done_id_d = gnt_sel_s;
                        state_d   = ST_IDLE;
                    end else begin
`ifdef TX_SCHED_CRC_EN
                        state_d = ST_CRC;
`else
                        state_d = ST_LAUNCH;
`endif
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CRC: begin
`ifdef TX_SCHED_CRC_EN
                crc_d      = crc8_byte(crc_q, bits_q[{byte_idx_q, 3'b000} +: 8]);
                byte_idx_d = byte_idx_q + 4'd1;
                if (byte_idx_q == (size_q - 4'd1)) begin
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_CRC;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_LAUNCH: begin
                wait_cnt_d = 4'd0;
                state_d    = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (!txi) begin
                    state_d = ST_WAIT_END;
                end else if (wait_cnt_q == 4'd13) begin
                    // Fourteen idle cycles here puts done/err 15 cycles after tf.
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    done_id_d = gnt_id_q;
                    state_d   = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            ST_WAIT_END: begin
                if (txi) begin
                    done_d    = 1'b1;
                    done_id_d = gnt_id_q;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_END;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            gnt_id_q   <= 1'b0;
            size_q     <= 4'd0;
            bits_q     <= 128'd0;
            baud_out_q <= 8'd16;
            baud_reg_q <= 8'd16;
            wait_cnt_q <= 4'd0;
            done_q     <= 1'b0;
            done_id_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_id_q   <= gnt_id_d;
            size_q     <= size_d;
            bits_q     <= bits_d;
            baud_out_q <= baud_out_d;
            baud_reg_q <= baud_reg_d;
            wait_cnt_q <= wait_cnt_d;
            done_q     <= done_d;
            done_id_q  <= done_id_d;
            err_q      <= err_d;
        end
    end

`ifdef TX_SCHED_CRC_EN
    // CRC accumulator and byte pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q      <= 8'h00;
            byte_idx_q <= 4'd0;
        end else begin
            crc_q      <= crc_d;
            byte_idx_q <= byte_idx_d;
        end
    end
    assign crc = crc_q;
`else
    assign crc = 8'h00;
`endif

    assign tf        = (state_q == ST_LAUNCH);
    assign busy      = (state_q != ST_IDLE);
    assign framesize = size_q;
    assign framebits = bits_q;
    assign baudrate  = baud_out_q;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign err       = err_q;

endmodule
